// File: rtl/lab5_g41_alu_arbiter.sv
// Two-port round-robin front end for an external combinational ALU; one transaction in flight.
// Optional error counter enabled by defining ALU_ARB_ERRCNT_EN.
module lab5_g41_alu_arbiter #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [W-1:0]   rsp0_s,
  output logic [4:0]     rsp0_flags,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp1_s,
  output logic [4:0]     rsp1_flags,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_s,
  input  logic           alu_n,
  input  logic           alu_z,
  input  logic           alu_v,
  input  logic           alu_c,
  input  logic           alu_hata,
`ifdef ALU_ARB_ERRCNT_EN
  output logic [7:0]     err_cnt,
`endif
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic           own_q, own_d;
  logic           last_q, last_d;
  logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   res_s_q, res_s_d;
  logic [4:0]     res_f_q, res_f_d;
  logic           gnt, acc0, acc1, own_rdy;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    gnt  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    acc0 = (state_q == IDLE) && req0_valid && !gnt;
    acc1 = (state_q == IDLE) && req1_valid && gnt;
    own_rdy = own_q ? rsp1_ready : rsp0_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_s_q  <= '0;
      res_f_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_s_q  <= res_s_d;
      res_f_q  <= res_f_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc0 || acc1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (own_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_d    = own_q;
    last_d   = last_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_s_d  = res_s_q;
    res_f_d  = res_f_q;
    if (acc0 || acc1) begin
      own_d    = acc1;
      last_d   = acc1;
      alu_a_d  = acc1 ? req1_a  : req0_a;
      alu_b_d  = acc1 ? req1_b  : req0_b;
      alu_op_d = acc1 ? req1_op : req0_op;
    end
    // A flagged ALU error is reported, not treated as an abort.
    if (state_q == EXEC) begin
      res_s_d = alu_s;
      res_f_d = {alu_hata, alu_n, alu_z, alu_v, alu_c};
    end
  end

  always_comb begin
    req0_ready = acc0;
    req1_ready = acc1;
    rsp0_valid = (state_q == RESP) && !own_q;
    rsp1_valid = (state_q == RESP) && own_q;
    busy       = (state_q != IDLE);
    rsp0_s     = res_s_q;
    rsp1_s     = res_s_q;
    rsp0_flags = res_f_q;
    rsp1_flags = res_f_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_op     = alu_op_q;
  end

`ifdef ALU_ARB_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == EXEC && alu_hata && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_lab5_g41_alu_arbiter.sv
// Directed bench for lab5_g41_alu_arbiter with a small behavioural ALU attached.
module tb_lab5_g41_alu_arbiter;
  localparam int W = 32, OPW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [OPW-1:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [W-1:0] rsp0_s, rsp1_s, alu_a, alu_b, alu_s;
  logic [4:0] rsp0_flags, rsp1_flags;
  logic [OPW-1:0] alu_op;
  logic alu_n, alu_z, alu_v, alu_c, alu_hata;
`ifdef ALU_ARB_ERRCNT_EN
  logic [7:0] err_cnt;
`endif
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  lab5_g41_alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .alu_hata(alu_hata),
`ifdef ALU_ARB_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  // 0000 add, 0001 sub (c = no borrow), 0010 and, 1111 error op returning DEADBEEF.
  logic [W:0] wide;
  always_comb begin
    wide = '0; alu_v = 1'b0; alu_hata = 1'b0;
    case (alu_op)
      4'b0000: begin
        wide  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[W-1] == alu_b[W-1]) && (wide[W-1] != alu_a[W-1]);
      end
      4'b0001: begin
        wide  = {1'b0, alu_a} + {1'b0, ~alu_b} + 1;
        alu_v = (alu_a[W-1] != alu_b[W-1]) && (wide[W-1] != alu_a[W-1]);
      end
      4'b0010: wide = {1'b0, alu_a & alu_b};
      4'b1111: begin wide = {1'b0, 32'hDEAD_BEEF}; alu_hata = 1'b1; end
      default: wide = '0;
    endcase
    alu_s = wide[W-1:0];
    alu_c = wide[W];
    alu_n = alu_s[W-1];
    alu_z = (alu_s == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
`ifdef ALU_ARB_ERRCNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    tick(); rst_n = 1;

    // Single add on port 0
    req0_valid = 1; req0_a = 41; req0_b = 34; req0_op = 4'b0000; rsp0_ready = 1;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    tick(); req0_valid = 0; #1;
    chk("t1_busy", busy, 1);
    chk("t1_alu_a", alu_a, 41);
    chk("t1_alu_b", alu_b, 34);
    chk("t1_rsp0_valid_exec", rsp0_valid, 0);
    tick();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_s", rsp0_s, 75);
    chk("t1_rsp0_flags", rsp0_flags, 5'b00000);
    chk("t1_rsp1_valid", rsp1_valid, 0);
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rsp0_valid", rsp0_valid, 0);

    // Tie after reset: port 0 first, port 1 after the response
    rst_n = 0; #1; rst_n = 1;
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 4'b0001;
    req1_valid = 1; req1_a = 3; req1_b = 3; req1_op = 4'b0001;
    rsp0_ready = 1; rsp1_ready = 0;
    #1;
    chk("t2_req0_ready", req0_ready, 1);
    chk("t2_req1_ready", req1_ready, 0);
    tick(); req0_valid = 0; #1;
    chk("t2_exec_req1_ready", req1_ready, 0);
    tick();
    chk("t2_rsp0_valid", rsp0_valid, 1);
    chk("t2_rsp0_s", rsp0_s, 32'hFFFF_FFFE);
    chk("t2_rsp0_flags", rsp0_flags, 5'b01000);
    chk("t2_resp_exit_req1_ready", req1_ready, 0);
    tick();
    chk("t2_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 4'b1111;
    tick();
    // Port 1 stalls its response; port 0's rsp_ready must be ignored
    for (int i = 0; i < 5; i++) begin
      chk("t3_rsp1_valid", rsp1_valid, 1);
      chk("t3_rsp1_s", rsp1_s, 0);
      chk("t3_rsp1_flags", rsp1_flags, 5'b00101);
      chk("t3_req0_ready", req0_ready, 0);
      chk("t3_rsp0_valid", rsp0_valid, 0);
      tick();
    end
    rsp1_ready = 1;
    tick();
    chk("t3_req0_ready_after", req0_ready, 1);
    tick(); req0_valid = 0;
    tick();
    chk("t4_rsp0_valid", rsp0_valid, 1);
    chk("t4_rsp0_s", rsp0_s, 32'hDEAD_BEEF);
    chk("t4_rsp0_flags", rsp0_flags, 5'b11000);
`ifdef ALU_ARB_ERRCNT_EN
    chk("t4_err_cnt", err_cnt, 1);
`endif
    tick();
    chk("t4_idle_busy", busy, 0);

    // Reset during EXEC
    req0_valid = 1; req0_a = 3; req0_b = 6; req0_op = 4'b0010;
    tick(); req0_valid = 0; #1;
    chk("t5_exec_busy", busy, 1);
    chk("t5_exec_alu_op", alu_op, 2);
    rst_n = 0; #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_alu_op", alu_op, 0);
    chk("t5_rst_alu_a", alu_a, 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_rsp0", rsp0_valid, 0);
      chk("t5_no_busy", busy, 0);
    end

`ifdef ALU_ARB_ERRCNT_EN
    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      req0_valid = 1; req0_op = 4'b1111;
      tick(); req0_valid = 0;
      tick(); tick();
    end
    chk("t6_err_cnt_sat", err_cnt, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lab5_g41_alu_arbiter.md
LAB5_G41_ALU_ARBITER -- requirements
Module: lab5_g41_alu_arbiter

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width.
REQ-002 SHALL have parameter: OPW, 4, ALU opcode width.
REQ-003 SHALL have single clock clk and asynchronous active-low reset rst_n; all state on rising clk.
REQ-004 SHALL have ports: clk  in  1  clock.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 reqN_valid  in  1  request N (N=0,1) valid.
REQ-007 reqN_ready  out  1  request N accepted this cycle.
REQ-008 reqN_a, reqN_b  in  W  operands.
REQ-009 reqN_op  in  OPW  opcode.
REQ-010 rspN_valid  out  1  response N valid.
REQ-011 rspN_ready  in  1  response N consumed.
REQ-012 rspN_s  out  W  result.
REQ-013 rspN_flags  out  5  {hata,n,z,v,c}.
REQ-014 alu_a, alu_b  out  W  registered ALU operands.
REQ-015 alu_op  out  OPW  registered ALU opcode.
REQ-016 alu_s  in  W  ALU result (combinational from alu_a/b/op).
REQ-017 alu_n, alu_z, alu_v, alu_c, alu_hata  in  1  ALU flags.
REQ-018 busy  out  1  high when FSM not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; one transaction in flight.
REQ-020 In IDLE, reqN_ready SHALL be combinational: high only for granted port with reqN_valid=1; never both high.
REQ-021 Arbitration SHALL be round-robin: if both valid, grant port not granted last; single valid port always granted.
REQ-022 Handshake: accept on reqN_valid&reqN_ready at edge t; operands/op registered onto alu_a/b/op; FSM -> EXEC.
REQ-023 In EXEC (cycle t+1) SHALL capture alu_s and flags into result registers at end of cycle; FSM -> RESP.
REQ-024 In RESP, rspN_valid SHALL be high only for owning port, from cycle t+2 until rspN_ready=1; then FSM -> IDLE.
REQ-025 rspN_s/rspN_flags SHALL stay stable while rspN_valid=1 and rspN_ready=0.
REQ-026 New request SHALL not be accepted in the RESP-exit cycle; earliest next accept is the cycle after return to IDLE.
REQ-027 alu_hata=1 SHALL not abort; result and flags returned unchanged with flags[4]=1.
REQ-028 reqN_valid dropped before acceptance SHALL cause no state change.
REQ-029 rspN_ready for non-owning port SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: FSM IDLE, alu_a/alu_b/alu_op=0, result/flag registers=0, rspN_valid=0, reqN_ready=0, busy=0, last grant=1 (port 0 wins first tie).
REQ-031 Reset mid-transaction SHALL discard pending result; no response after reset release.

Configuration
REQ-032 With ALU_ARB_ERRCNT_EN defined, SHALL add output err_cnt (8 bits), reset 0, incremented once per EXEC capture with alu_hata=1, saturating at 255.
REQ-033 Without ALU_ARB_ERRCNT_EN, err_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 req0 a=41 b=34 op=4'b0000, rsp0_ready=1 -> accept cycle t, alu_a=41/alu_b=34 at t+1, rsp0_valid at t+2 with rsp0_s = model result for op 0000.
REQ-035 req0 and req1 valid same cycle after reset -> req0 granted first, req1 granted in the first IDLE cycle after rsp0 handshake.
REQ-036 rsp1_ready held 0 for 5 cycles -> rsp1_valid, rsp1_s, rsp1_flags stable; req0_ready=0 throughout.
REQ-037 Model asserts alu_hata for op=4'b1111 -> rsp flags[4]=1; with ALU_ARB_ERRCNT_EN, err_cnt 0->1; 300 such ops -> err_cnt=255.
REQ-038 rst_n pulsed low during EXEC -> busy=0 and alu_op=0 immediately; no rspN_valid after release.
